alu_disp_seq: RTL and testbench

//  Registered, parametrised successor to the combinational ALU/decoder/display-mux path.
//  - Captures operands on a start request, computes the result in a small FSM and holds it.
//  - Drives a time-multiplexed 7-segment display showing the result as 3-bit digits.
//  - Each digit is shown as plain octal or as the octal form of the Gray-coded result.
//  - Sits between the user input pins and the display pins of the top-level wrapper.

---
 rtl/alu_disp_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_disp_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_disp_seq.sv
// rtl/alu_disp_seq.sv - registered ALU with octal/Gray time-multiplexed 7-segment display
// Optional feature macro ALU_OVF_FLAG_EN adds ovf_out and a DP bit (seg_out[7]).
module alu_disp_seq #(
  parameter int W        = 5,
  parameter int NDIG     = 2,
  parameter int SCAN_DIV = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    a_in,
  input  logic [W-1:0]    b_in,
  input  logic [1:0]      op_in,
  input  logic            mode_in,
  input  logic            start_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [W:0]      result_out,
`ifdef ALU_OVF_FLAG_EN
  output logic            ovf_out,
  output logic [7:0]      seg_out,
`else
  output logic [6:0]      seg_out,
`endif
  output logic [NDIG-1:0] dig_out
);

  localparam int RW = W + 1;
  localparam int DW = 3 * NDIG;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_r, b_r;
  logic [1:0]      op_r;
  logic            mode_r;
  logic [RW-1:0]   add_res, sub_res, alu_res;
  logic [CW-1:0]   scan_cnt;
  logic [IW-1:0]   dig_idx;
  logic [RW-1:0]   disp_val;
  logic [DW-1:0]   disp_ext;
  logic [2:0]      cur_digit;

  assign add_res = {1'b0, a_r} + {1'b0, b_r};
  assign sub_res = {1'b0, a_r} - {1'b0, b_r};

  always_comb begin
    alu_res = '0;
    case (op_r)
      2'b00:   alu_res = add_res;
      2'b01:   alu_res = sub_res;
      2'b10:   alu_res = {1'b0, a_r & b_r};
      default: alu_res = {1'b0, a_r | b_r};
    endcase
  end

`ifdef ALU_OVF_FLAG_EN
  logic alu_ovf;

  // Signed overflow: operands agree (ADD) or differ (SUB) in sign and the W-bit result disagrees with A.
  always_comb begin
    alu_ovf = 1'b0;
    case (op_r)
      2'b00:   alu_ovf = (a_r[W-1] == b_r[W-1]) && (add_res[W-1] != a_r[W-1]);
      2'b01:   alu_ovf = (a_r[W-1] != b_r[W-1]) && (sub_res[W-1] != a_r[W-1]);
      default: alu_ovf = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= '0;
      mode_r     <= 1'b0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      result_out <= '0;
`ifdef ALU_OVF_FLAG_EN
      ovf_out    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            a_r      <= a_in;
            b_r      <= b_in;
            op_r     <= op_in;
            mode_r   <= mode_in;
            busy_out <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          result_out <= alu_res;
`ifdef ALU_OVF_FLAG_EN
          ovf_out    <= alu_ovf;
`endif
          busy_out   <= 1'b0;
          done_out   <= 1'b1;
          state      <= DONE;
        end
        default: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [2:0] v);
    case (v)
      3'd0:    seg7 = 7'h3F;
      3'd1:    seg7 = 7'h06;
      3'd2:    seg7 = 7'h5B;
      3'd3:    seg7 = 7'h4F;
      3'd4:    seg7 = 7'h66;
      3'd5:    seg7 = 7'h6D;
      3'd6:    seg7 = 7'h7D;
      default: seg7 = 7'h07;
    endcase
  endfunction

  assign disp_val = mode_r ? (result_out ^ (result_out >> 1)) : result_out;

  always_comb begin
    disp_ext           = '0;
    disp_ext[RW-1:0]   = disp_val;
    cur_digit          = disp_ext[3*int'(dig_idx) +: 3];
  end

  // seg_out and dig_out are both registered from the same dig_idx, so they switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      dig_out  <= NDIG'(1);
`ifdef ALU_OVF_FLAG_EN
      seg_out  <= 8'h3F;
`else
      seg_out  <= 7'h3F;
`endif
    end else begin
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig_idx  <= (dig_idx == IW'(NDIG - 1)) ? '0 : dig_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      dig_out <= NDIG'(1) << dig_idx;
`ifdef ALU_OVF_FLAG_EN
      seg_out <= {ovf_out, seg7(cur_digit)};
`else
      seg_out <= seg7(cur_digit);
`endif
    end
  end

endmodule

// File: tb/tb_alu_disp_seq.sv
// tb/tb_alu_disp_seq.sv - directed self-checking bench for alu_disp_seq (W=5, NDIG=2, SCAN_DIV=4)
module tb_alu_disp_seq;
  localparam int W        = 5;
  localparam int NDIG     = 2;
  localparam int SCAN_DIV = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [W-1:0]    a_in = '0, b_in = '0;
  logic [1:0]      op_in = '0;
  logic            mode_in = 1'b0, start_in = 1'b0;
  logic            busy, done;
  logic [W:0]      result;
  logic [7:0]      seg;
  logic [NDIG-1:0] dig;
`ifdef ALU_OVF_FLAG_EN
  logic            ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  alu_disp_seq #(.W(W), .NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .mode_in(mode_in), .start_in(start_in), .busy_out(busy), .done_out(done),
    .result_out(result),
`ifdef ALU_OVF_FLAG_EN
    .ovf_out(ovf), .seg_out(seg),
`else
    .seg_out(seg[6:0]),
`endif
    .dig_out(dig)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic mode, input logic [W:0] exp_res);
    @(negedge clk);
    a_in = a; b_in = b; op_in = op; mode_in = mode; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " done early"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, " busy off"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " result"}, 32'(result), 32'(exp_res));
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  task automatic wait_dig(input string tag, input logic [NDIG-1:0] target);
    for (int i = 0; i < 16 && dig !== target; i++) @(negedge clk);
    chk({tag, " dig"}, 32'(dig), 32'(target));
  endtask

  task automatic check_display(input string tag, input logic [6:0] e0, input logic [6:0] e1);
    repeat (2) @(negedge clk);
    wait_dig(tag, 2'b01);
    chk({tag, " seg digit0"}, 32'(seg[6:0]), 32'(e0));
    wait_dig(tag, 2'b10);
    chk({tag, " seg digit1"}, 32'(seg[6:0]), 32'(e1));
  endtask

  initial begin
    int n;
    // 1. reset
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset dig", 32'(dig), 32'h1);
    chk("reset seg", 32'(seg[6:0]), 32'h3F);
`ifdef ALU_OVF_FLAG_EN
    chk("reset ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset dig", 32'(dig), 32'h1);
    chk("post reset seg", 32'(seg[6:0]), 32'h3F);
    wait_dig("scan first", 2'b10);
    n = 0;
    while (dig === 2'b10 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("scan slot length", 32'(n), 32'd4);

    // 2. ADD 13+9 = 22 (octal 26)
    run_op("add", 5'd13, 5'd9, 2'b00, 1'b0, 6'd22);
    check_display("add disp", 7'h7D, 7'h5B);

    // 3. same in Gray mode -> 29 (octal 35)
    run_op("add gray", 5'd13, 5'd9, 2'b00, 1'b1, 6'd22);
    check_display("gray disp", 7'h6D, 7'h4F);

    // 4. SUB 3-5 = 62 (octal 76), then ADD 15+1 signed overflow
    run_op("sub", 5'd3, 5'd5, 2'b01, 1'b0, 6'd62);
`ifdef ALU_OVF_FLAG_EN
    chk("sub ovf", 32'(ovf), 32'd0);
`endif
    check_display("sub disp", 7'h7D, 7'h07);
    run_op("add ovf", 5'd15, 5'd1, 2'b00, 1'b0, 6'd16);
`ifdef ALU_OVF_FLAG_EN
    chk("add ovf flag", 32'(ovf), 32'd1);
    repeat (2) @(negedge clk);
    chk("add ovf dp", 32'(seg[7]), 32'd1);
`endif
    check_display("add ovf disp", 7'h3F, 7'h5B);

    // 5. AND, then OR with start pulsed across CALC and DONE
    run_op("and", 5'd21, 5'd14, 2'b10, 1'b0, 6'd4);
    @(negedge clk);
    a_in = 5'd21; b_in = 5'd14; op_in = 2'b11; start_in = 1'b1;
    n = 0;
    @(negedge clk);
    chk("or busy", 32'(busy), 32'd1);
    @(negedge clk);
    if (done === 1'b1) n++;
    @(negedge clk);
    start_in = 1'b0;
    if (done === 1'b1) n++;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) n++;
      chk("or no restart busy", 32'(busy), 32'd0);
    end
    chk("or done count", 32'(n), 32'd1);
    chk("or result", 32'(result), 32'd31);

    // start held high restarts every 3 cycles
    @(negedge clk);
    a_in = 5'd1; b_in = 5'd1; op_in = 2'b00; start_in = 1'b1;
    @(negedge clk); chk("held busy c1", 32'(busy), 32'd1);
    @(negedge clk); chk("held busy c2", 32'(busy), 32'd0);
    @(negedge clk); chk("held busy c3", 32'(busy), 32'd0);
    @(negedge clk); chk("held busy c4", 32'(busy), 32'd1);
    start_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("held result", 32'(result), 32'd2);

    // 6. reset during CALC
    @(negedge clk);
    a_in = 5'd7; b_in = 5'd2; op_in = 2'b01; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    chk("midrst busy before", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst result", 32'(result), 32'd0);
    chk("midrst dig", 32'(dig), 32'h1);
    chk("midrst seg", 32'(seg[6:0]), 32'h3F);
    repeat (2) begin
      @(negedge clk);
      chk("midrst no done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst after release done", 32'(done), 32'd0);
    run_op("after rst", 5'd7, 5'd2, 2'b01, 1'b0, 6'd5);
    check_display("after rst disp", 7'h6D, 7'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
